// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending coin-path controller.
//   state_t      controller states
//   COIN_*       2-bit coin acceptor codes
//   VAL_*        coin values in cents
//   coin_value() maps a coin code to its value; cancel and none are worth 0
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      DISPENSE = 2'd2,
      CHANGE   = 2'd3
   } state_t;

   localparam logic [1:0] COIN_NONE   = 2'b00;
   localparam logic [1:0] COIN_NICKEL = 2'b01;
   localparam logic [1:0] COIN_DIME   = 2'b10;
   localparam logic [1:0] COIN_CANCEL = 2'b11;

   localparam int VAL_NICKEL = 5;
   localparam int VAL_DIME   = 10;

   function automatic int coin_value(input logic [1:0] code);
      int val;
      case (code)
         COIN_NICKEL: val = VAL_NICKEL;
         COIN_DIME:   val = VAL_DIME;
         COIN_NONE:   val = 0;
         default:     val = 0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/vend_change_gen.sv
// vend_change_gen: greedy change payout, one coin per cycle.
// Fed the amount still owed each cycle; while step is high it issues a
// registered dime pulse if 10 or more is owed, otherwise a nickel pulse if
// 5 is owed, and reports the amount remaining after that coin.
//   clk, rstn    clock, async active-low reset
//   step         payout active this cycle
//   amount       amount currently owed (cents)
//   amount_next  amount owed after this cycle's coin
//   done         nothing left to pay
//   dime/nickel  1-cycle eject pulses
module vend_change_gen
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 6
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                step,
   input  logic [CREDIT_W-1:0] amount,
   output logic [CREDIT_W-1:0] amount_next,
   output logic                done,
   output logic                dime,
   output logic                nickel
);

   localparam logic [CREDIT_W-1:0] DIME_C   = CREDIT_W'(VAL_DIME);
   localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(VAL_NICKEL);

   logic pick_dime;
   logic pick_nickel;

   always_comb begin
      pick_dime   = 1'b0;
      pick_nickel = 1'b0;
      amount_next = amount;
      if (amount >= DIME_C) begin
         pick_dime   = 1'b1;
         amount_next = amount - DIME_C;
      end else if (amount >= NICKEL_C) begin
         pick_nickel = 1'b1;
         amount_next = amount - NICKEL_C;
      end
   end

   assign done = (amount == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dime   <= 1'b0;
         nickel <= 1'b0;
      end else begin
         dime   <= step & pick_dime;
         nickel <= step & pick_nickel;
      end
   end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending machine coin-path controller.
// Accumulates credit from the coin acceptor, starts a dispense when an item
// is requested with enough credit, handshakes with the dispenser, then pays
// back remaining credit one coin per cycle. All outputs are registered.
// Optional macro VEND_TIMEOUT_EN adds a dispenser ack timeout with a fault
// pulse and full refund; without it DISPENSE waits indefinitely.
//   clk, rstn    clock, async active-low reset
//   coin         acceptor code: 00 none, 01 nickel, 10 dime, 11 cancel
//   sel          item request (level)
//   disp_ack     dispenser done
//   disp_req     dispense request, held until disp_ack
//   chg_nickel   eject one nickel (pulse)
//   chg_dime     eject one dime (pulse)
//   coin_reject  inserted coin refused (pulse)
//   credit       current credit in cents
//   busy         dispensing or paying change
//   fault        ack timeout (pulse, VEND_TIMEOUT_EN only)
//
// state    | meaning
// ---------+--------------------------------------------
// IDLE     | no credit
// COLLECT  | credit > 0, accepting coins / sel / cancel
// DISPENSE | disp_req high, waiting for disp_ack
// CHANGE   | paying back credit, one coin per cycle
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int PRICE       = 15,
   parameter int MAX_CREDIT  = 40,
   parameter int CREDIT_W    = 6,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [1:0]          coin,
   input  logic                sel,
   input  logic                disp_ack,
   output logic                disp_req,
   output logic                chg_nickel,
   output logic                chg_dime,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
`ifdef VEND_TIMEOUT_EN
   output logic                fault,
`endif
   output logic                busy
);

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);

   if ((PRICE % 5) != 0 || (MAX_CREDIT % 5) != 0 || PRICE > MAX_CREDIT ||
       MAX_CREDIT >= (1 << CREDIT_W) || ACK_TIMEOUT < 1) begin : g_param_check
      $error("vend_ctrl: inconsistent PRICE/MAX_CREDIT/CREDIT_W/ACK_TIMEOUT");
   end

   state_t              state, state_n;
   logic [CREDIT_W-1:0] credit_n;
   logic                disp_req_n;
   logic                reject_n;
   logic                fault_n;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W:0]   coin_sum;
   logic                is_coin;
   logic [CREDIT_W-1:0] chg_amount_next;
   logic                chg_done;
   logic                tmr_expired;

   assign coin_val = CREDIT_W'(coin_value(coin));
   assign is_coin  = (coin == COIN_NICKEL) || (coin == COIN_DIME);
   // One extra bit so an over-ceiling coin cannot wrap before the compare.
   assign coin_sum = {1'b0, credit} + {1'b0, coin_val};

`ifdef VEND_TIMEOUT_EN
   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

   // Down-counter loaded on DISPENSE entry; terminal count 0 marks the last
   // cycle in which disp_ack can still arrive.
   logic [TMR_W-1:0] tmr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tmr <= '0;
      end else if (state != DISPENSE) begin
         tmr <= TMR_LOAD;
      end else if (tmr != '0) begin
         tmr <= tmr - 1'b1;
      end
   end

   assign tmr_expired = (tmr == '0);
`else
   assign tmr_expired = 1'b0;
`endif

   vend_change_gen #(
      .CREDIT_W (CREDIT_W)
   ) u_change_gen (
      .clk         (clk),
      .rstn        (rstn),
      .step        (state == CHANGE),
      .amount      (credit),
      .amount_next (chg_amount_next),
      .done        (chg_done),
      .dime        (chg_dime),
      .nickel      (chg_nickel)
   );

   always_comb begin
      state_n    = state;
      credit_n   = credit;
      disp_req_n = disp_req;
      reject_n   = 1'b0;
      fault_n    = 1'b0;
      case (state)
         IDLE, COLLECT: begin
            if (state == COLLECT && coin == COIN_CANCEL) begin
               state_n = CHANGE;
            end else if (sel && credit >= PRICE_C) begin
               // A coin arriving with a valid request loses to the request.
               credit_n   = credit - PRICE_C;
               state_n    = DISPENSE;
               disp_req_n = 1'b1;
               reject_n   = is_coin;
            end else if (is_coin) begin
               if (coin_sum <= MAX_C) begin
                  credit_n = coin_sum[CREDIT_W-1:0];
                  state_n  = COLLECT;
               end else begin
                  reject_n = 1'b1;
               end
            end
         end
         DISPENSE: begin
            reject_n = is_coin;
            if (disp_ack) begin
               disp_req_n = 1'b0;
               state_n    = (credit != '0) ? CHANGE : IDLE;
            end else if (tmr_expired) begin
               disp_req_n = 1'b0;
               fault_n    = 1'b1;
               credit_n   = credit + PRICE_C;
               state_n    = CHANGE;
            end
         end
         CHANGE: begin
            reject_n = is_coin;
            if (chg_done) begin
               state_n = IDLE;
            end else begin
               credit_n = chg_amount_next;
            end
         end
         default: begin
            state_n    = IDLE;
            credit_n   = '0;
            disp_req_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         credit      <= '0;
         disp_req    <= 1'b0;
         coin_reject <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         credit      <= credit_n;
         disp_req    <= disp_req_n;
         coin_reject <= reject_n;
         busy        <= (state_n == DISPENSE) || (state_n == CHANGE);
      end
   end

`ifdef VEND_TIMEOUT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fault <= 1'b0;
      end else begin
         fault <= fault_n;
      end
   end
`else
   logic unused_fault;
   assign unused_fault = fault_n;
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
module tb_vend_ctrl;

   localparam int TMO = 8;
   localparam int PRICE = 15;
   localparam int MAXC = 40;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [1:0] coin = 2'b00;
   logic       sel = 1'b0;
   logic       disp_ack = 1'b0;
   logic       disp_req, chg_nickel, chg_dime, coin_reject, busy;
   logic [5:0] credit;
`ifdef VEND_TIMEOUT_EN
   logic       fault;
`endif

   int n_checks = 0;
   int n_errors = 0;

   vend_ctrl #(
      .PRICE       (PRICE),
      .MAX_CREDIT  (MAXC),
      .CREDIT_W    (6),
      .ACK_TIMEOUT (TMO)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .coin        (coin),
      .sel         (sel),
      .disp_ack    (disp_ack),
      .disp_req    (disp_req),
      .chg_nickel  (chg_nickel),
      .chg_dime    (chg_dime),
      .coin_reject (coin_reject),
      .credit      (credit),
`ifdef VEND_TIMEOUT_EN
      .fault       (fault),
`endif
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got no finish, expected finish before 2ms");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       rstn;
      logic [1:0] coin;
      logic       sel;
      logic       ack;
      int         credit;
      logic       req;
      logic       nick;
      logic       dime;
      logic       rej;
      logic       busy;
   } vec_t;

   vec_t tbl[$];

   task automatic v(input logic r, input logic [1:0] c, input logic s, input logic a,
                    input int cr, input logic rq, input logic n, input logic d,
                    input logic j, input logic b);
      vec_t e;
      e.rstn = r; e.coin = c; e.sel = s; e.ack = a;
      e.credit = cr; e.req = rq; e.nick = n; e.dime = d; e.rej = j; e.busy = b;
      tbl.push_back(e);
   endtask

   // Reference model: credit as an integer, payout as a queue of coin values
   // worked out up front by greedy division.
   int  m_credit;
   bit  m_disp, m_pay, m_fault, m_nick, m_dime, m_rej;
   int  m_wait;
   int  m_q[$];

   task automatic m_start_payout();
      m_pay = 1;
      m_q.delete();
      for (int k = 0; k < m_credit / 10; k++) m_q.push_back(10);
      if (m_credit % 10 != 0) m_q.push_back(5);
   endtask

   task automatic model_edge(input logic r, input logic [1:0] c, input logic s, input logic a);
      int val, got;
      val = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
      m_nick = 0; m_dime = 0; m_rej = 0; m_fault = 0;
      if (!r) begin
         m_credit = 0; m_disp = 0; m_pay = 0; m_q.delete();
      end else if (m_pay) begin
         m_rej = (val != 0);
         if (m_q.size() != 0) begin
            got = m_q.pop_front();
            m_credit -= got;
            if (got == 10) m_dime = 1; else m_nick = 1;
         end else begin
            m_pay = 0;
         end
      end else if (m_disp) begin
         m_rej = (val != 0);
         m_wait++;
         if (a) begin
            m_disp = 0;
            if (m_credit > 0) m_start_payout();
         end
`ifdef VEND_TIMEOUT_EN
         else if (m_wait == TMO) begin
            m_disp = 0;
            m_fault = 1;
            m_credit += PRICE;
            m_start_payout();
         end
`endif
      end else begin
         if (c == 2'b11 && m_credit > 0) begin
            m_start_payout();
         end else if (s && m_credit >= PRICE) begin
            m_credit -= PRICE;
            m_disp = 1;
            m_wait = 0;
            m_rej = (val != 0);
         end else if (val != 0) begin
            if (m_credit + val <= MAXC) m_credit += val;
            else m_rej = 1;
         end
      end
   endtask

   initial begin
      int hi;
      int rc;

      // dime, nickel, sel, ack -> no change
      v(0,0,0,0,  0,0,0,0,0,0);
      v(1,0,0,0,  0,0,0,0,0,0);
      v(1,2,0,0, 10,0,0,0,0,0);
      v(1,1,0,0, 15,0,0,0,0,0);
      v(1,0,1,0,  0,1,0,0,0,1);
      v(1,0,0,0,  0,1,0,0,0,1);
      v(1,0,0,1,  0,0,0,0,0,0);
      v(1,0,0,0,  0,0,0,0,0,0);
      // dime x3, sel, ack -> dime then nickel
      v(1,2,0,0, 10,0,0,0,0,0);
      v(1,2,0,0, 20,0,0,0,0,0);
      v(1,2,0,0, 30,0,0,0,0,0);
      v(1,0,1,0, 15,1,0,0,0,1);
      v(1,0,0,1, 15,0,0,0,0,1);
      v(1,0,0,0,  5,0,0,1,0,1);
      v(1,0,0,0,  0,0,1,0,0,1);
      v(1,0,0,0,  0,0,0,0,0,0);
      // fill to ceiling, nickel rejected, cancel -> four dimes
      v(1,2,0,0, 10,0,0,0,0,0);
      v(1,2,0,0, 20,0,0,0,0,0);
      v(1,2,0,0, 30,0,0,0,0,0);
      v(1,2,0,0, 40,0,0,0,0,0);
      v(1,1,0,0, 40,0,0,0,1,0);
      v(1,0,0,0, 40,0,0,0,0,0);
      v(1,3,0,0, 40,0,0,0,0,1);
      v(1,0,0,0, 30,0,0,1,0,1);
      v(1,0,0,0, 20,0,0,1,0,1);
      v(1,0,0,0, 10,0,0,1,0,1);
      v(1,0,0,0,  0,0,0,1,0,1);
      v(1,0,0,0,  0,0,0,0,0,0);
      // sel + dime together at 20, dime during DISPENSE
      v(1,2,0,0, 10,0,0,0,0,0);
      v(1,2,0,0, 20,0,0,0,0,0);
      v(1,2,1,0,  5,1,0,0,1,1);
      v(1,2,0,0,  5,1,0,0,1,1);
      v(1,0,0,1,  5,0,0,0,0,1);
      v(1,0,0,0,  0,0,1,0,0,1);
      v(1,0,0,0,  0,0,0,0,0,0);
      // short sel ignored, short sel does not block nickel, cancel beats sel
      v(1,2,0,0, 10,0,0,0,0,0);
      v(1,0,1,0, 10,0,0,0,0,0);
      v(1,1,1,0, 15,0,0,0,0,0);
      v(1,3,1,0, 15,0,0,0,0,1);
      v(1,0,0,0,  5,0,0,1,0,1);
      v(1,0,0,0,  0,0,1,0,0,1);
      v(1,0,0,0,  0,0,0,0,0,0);
      // cancel in IDLE ignored
      v(1,3,0,0,  0,0,0,0,0,0);
      // reset mid-CHANGE
      v(1,2,0,0, 10,0,0,0,0,0);
      v(1,2,0,0, 20,0,0,0,0,0);
      v(1,3,0,0, 20,0,0,0,0,1);
      v(1,0,0,0, 10,0,0,1,0,1);
      v(0,0,0,0,  0,0,0,0,0,0);
      v(1,0,0,0,  0,0,0,0,0,0);

      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         rstn = tbl[i].rstn; coin = tbl[i].coin; sel = tbl[i].sel; disp_ack = tbl[i].ack;
         tick();
         check($sformatf("tbl%0d credit", i), int'(credit), tbl[i].credit);
         check($sformatf("tbl%0d disp_req", i), int'(disp_req), int'(tbl[i].req));
         check($sformatf("tbl%0d chg_nickel", i), int'(chg_nickel), int'(tbl[i].nick));
         check($sformatf("tbl%0d chg_dime", i), int'(chg_dime), int'(tbl[i].dime));
         check($sformatf("tbl%0d coin_reject", i), int'(coin_reject), int'(tbl[i].rej));
         check($sformatf("tbl%0d busy", i), int'(busy), int'(tbl[i].busy));
      end

      // randomized run against the reference model
      for (int i = 0; i < 3000; i++) begin
         rstn = (i == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
         rc = $urandom_range(0, 9);
         coin = (rc < 4) ? 2'b00 : (rc < 6) ? 2'b01 : (rc < 9) ? 2'b10 : 2'b11;
         sel = ($urandom_range(0, 3) == 0);
         disp_ack = ($urandom_range(0, 5) == 0);
         model_edge(rstn, coin, sel, disp_ack);
         tick();
         check("rnd credit", int'(credit), m_credit);
         check("rnd disp_req", int'(disp_req), int'(m_disp));
         check("rnd chg_nickel", int'(chg_nickel), int'(m_nick));
         check("rnd chg_dime", int'(chg_dime), int'(m_dime));
         check("rnd coin_reject", int'(coin_reject), int'(m_rej));
         check("rnd busy", int'(busy), int'(m_disp | m_pay));
`ifdef VEND_TIMEOUT_EN
         check("rnd fault", int'(fault), int'(m_fault));
`endif
      end

      // reset drops disp_req without waiting for a clock edge
      coin = 2'b00; sel = 1'b0; disp_ack = 1'b0;
      rstn = 1'b0; tick(); rstn = 1'b1; tick();
      coin = 2'b10; tick();
      coin = 2'b01; tick();
      coin = 2'b00; sel = 1'b1; tick();
      sel = 1'b0;
      check("async pre disp_req", int'(disp_req), 1);
      #2 rstn = 1'b0;
      #1;
      check("async disp_req", int'(disp_req), 0);
      check("async credit", int'(credit), 0);
      check("async busy", int'(busy), 0);
      tick(); rstn = 1'b1; tick();

`ifdef VEND_TIMEOUT_EN
      // ack never arrives: request held TMO cycles, then fault and refund
      coin = 2'b10; tick();
      coin = 2'b01; tick();
      coin = 2'b00; sel = 1'b1; tick();
      sel = 1'b0;
      check("tmo disp_req start", int'(disp_req), 1);
      hi = 1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (!disp_req) break;
         hi++;
      end
      check("tmo req cycles", hi, TMO);
      check("tmo fault", int'(fault), 1);
      check("tmo credit", int'(credit), 15);
      check("tmo busy", int'(busy), 1);
      tick();
      check("tmo fault clear", int'(fault), 0);
      check("tmo dime", int'(chg_dime), 1);
      check("tmo credit5", int'(credit), 5);
      tick();
      check("tmo nickel", int'(chg_nickel), 1);
      check("tmo credit0", int'(credit), 0);
      tick();
      check("tmo idle", int'(busy), 0);
`else
      hi = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Controller for the newspaper/vending coin path. Accumulates credit from the coin acceptor and checks it against a price on a selection request.
- Sequences the item dispenser with a req/ack handshake, then pays back change one coin per cycle.
- Sits between the coin acceptor (2-bit coin code, sampled every clk) and the dispenser and change-hopper actuators.

Parameters:
- PRICE, 15: item price in cents. Must be a multiple of 5 and no greater than MAX_CREDIT.
- MAX_CREDIT, 40: credit ceiling in cents. Must be a multiple of 5.
- CREDIT_W, 6: width of the credit register. Must hold MAX_CREDIT.
- ACK_TIMEOUT, 255: cycles to wait for disp_ack. Used only with VEND_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- coin  in  2  coin code sampled every cycle: 00 none, 01 nickel (5), 10 dime (10), 11 cancel
- sel  in  1  item request, level sampled each cycle
- disp_ack  in  1  dispenser done; a 1-cycle pulse or level
- disp_req  out  1  dispense request, held until disp_ack is sampled
- chg_nickel  out  1  1-cycle pulse, eject one nickel
- chg_dime  out  1  1-cycle pulse, eject one dime
- coin_reject  out  1  1-cycle pulse, inserted coin refused (acceptor routes it to the return chute)
- credit  out  CREDIT_W  current credit in cents
- busy  out  1  high in DISPENSE or CHANGE
- fault  out  1  present only with VEND_TIMEOUT_EN; 1-cycle pulse on timeout

Behaviour:
- All outputs are registered.
- Reset: state IDLE, credit=0, all pulse and request outputs 0. Reset mid-operation abandons the transaction; credit is lost and disp_req drops asynchronously.
- States:
  - IDLE: credit==0.
  - COLLECT: credit>0, no transaction in flight.
  - DISPENSE: disp_req high.
  - CHANGE: paying back credit.
- IDLE/COLLECT, coin 01 or 10:
  - If credit+value <= MAX_CREDIT: credit += value next cycle; IDLE->COLLECT.
  - Otherwise: coin_reject pulses next cycle and credit is unchanged.
- IDLE/COLLECT, sel=1 with registered credit >= PRICE:
  - Next cycle: credit -= PRICE, state DISPENSE, disp_req=1.
  - If credit < PRICE, sel is ignored.
- Simultaneous coin 01/10 and a valid sel: sel wins, coin_reject pulses, and the coin is not credited. An invalid sel (credit short) does not block the coin.
- COLLECT, coin 11 (cancel): go to CHANGE with the full credit. Cancel takes priority over sel in the same cycle. Cancel in IDLE is ignored.
- DISPENSE:
  - disp_req stays 1 until disp_ack is sampled high.
  - Next cycle disp_req=0; state is CHANGE if credit>0, else IDLE.
  - Coins 01/10 arriving are rejected; cancel and sel are ignored.
- CHANGE, one coin per cycle:
  - credit>=10: chg_dime=1, credit-=10.
  - else credit==5: chg_nickel=1, credit-=5.
  - Leave for IDLE in the cycle after credit reaches 0.
  - Coins arriving are rejected; sel and cancel are ignored.
  - Example: 25 change gives dime, dime, nickel over 3 cycles, then IDLE.
- Latency:
  - Coin to credit update: 1 cycle.
  - sel to disp_req: 1 cycle.
  - disp_ack to first change pulse: 2 cycles (ack sampled -> CHANGE entered -> first pulse).
- Invariants:
  - credit is always a multiple of 5 and never exceeds MAX_CREDIT.
  - chg_nickel and chg_dime are never both high.
  - disp_req and any change pulse are never both high.
- busy = (state==DISPENSE || state==CHANGE).

Optional Feature:
- Macro VEND_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in DISPENSE.
  - If disp_ack has not arrived after ACK_TIMEOUT cycles: drop disp_req, pulse fault, add PRICE back to credit and go to CHANGE for a full refund.
  - A disp_ack in the same cycle as expiry counts as success.
- Not defined: no counter and no fault port; DISPENSE waits indefinitely.

Decomposition:
- Package vend_pkg:
  - State enum (IDLE, COLLECT, DISPENSE, CHANGE).
  - Coin code constants COIN_NONE, COIN_NICKEL, COIN_DIME, COIN_CANCEL.
  - Coin value constants VAL_NICKEL=5, VAL_DIME=10.
- One sub-module, vend_change_gen:
  - Loaded with an amount.
  - Emits dime/nickel pulses greedily.
  - Reports done when the amount reaches 0.

Test Plan:
- Dime, nickel, sel with PRICE=15 -> credit 10, then 15; disp_req 1 cycle after sel; ack -> IDLE; no change pulses.
- Dime x3, sel -> credit 30, then 15; after ack: chg_dime, then chg_nickel on consecutive cycles, credit 0, IDLE.
- Dime x4 (credit 40), then a nickel -> coin_reject pulse, credit stays 40; cancel -> 4 chg_dime pulses, IDLE.
- Credit 20, sel and dime in the same cycle -> dispense starts, coin_reject pulses, credit 5; a dime during DISPENSE -> coin_reject.
- Credit 10, sel -> ignored, disp_req stays 0; cancel together with sel at credit 15 -> refund of dime + nickel, no disp_req.
- VEND_TIMEOUT_EN, ACK_TIMEOUT=8, credit 15, sel, no ack -> disp_req drops after 8 cycles, fault pulses, dime + nickel refunded. Also assert rstn mid-CHANGE -> all outputs 0, credit 0.
